// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the single-port SRAM arbiter.
package sram_arbiter_pkg;

    localparam int         ADDR_W_DEF   = 20;
    localparam logic [3:0] SRAM_BE_IDLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWNER_IF,
        OWNER_D
    } owner_t;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one 32-bit asynchronous SRAM,
// holding strobes for WAIT_CYCLES and returning a one-cycle ready per access.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_ready,
    output logic              stall_req,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_wdata_oe,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              rd_done;
    logic              acc_d;

    // Only the word-address bits reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rd_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    owner_d = OWNER_D;
                    we_d    = d_we;
                    addr_d  = d_addr[ADDR_W+1:2];
                    be_d    = d_be;
                    wdata_d = d_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end else if (if_req) begin
                    owner_d = OWNER_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr[ADDR_W+1:2];
                    be_d    = '1;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    rd_done = ~we_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        acc_d = (state_d == ACCESS);
    end

    // Strobes are decoded from the next state so the SRAM pins come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= OWNER_IF;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            if_ready      <= 1'b0;
            d_ready       <= 1'b0;
            if_rdata      <= '0;
            d_rdata       <= '0;
            sram_wdata_oe <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_be_n     <= SRAM_BE_IDLE;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            cnt_q         <= cnt_d;
            if_ready      <= (state_d == DONE) && (owner_q == OWNER_IF);
            d_ready       <= (state_d == DONE) && (owner_q == OWNER_D);
            sram_wdata_oe <= acc_d & we_d;
            sram_ce_n     <= ~acc_d;
            sram_oe_n     <= ~(acc_d & ~we_d);
            sram_we_n     <= ~(acc_d & we_d);
            sram_be_n     <= acc_d ? (we_d ? ~be_d : '0) : SRAM_BE_IDLE;
            if (rd_done) begin
                if (owner_q == OWNER_D) d_rdata  <= sram_rdata;
                else                    if_rdata <= sram_rdata;
            end
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign stall_req  = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench: two arbiters (WAIT_CYCLES 1 and 3) on behavioural SRAMs.
module tb_sram_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic mem_load;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        if_req [2];
    logic [31:0] if_addr [2];
    logic [31:0] if_rdata [2];
    logic        if_ready [2];
    logic        d_req [2];
    logic        d_we [2];
    logic [3:0]  d_be [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];
    logic [31:0] d_rdata [2];
    logic        d_ready [2];
    logic        stall_req [2];
    logic [19:0] sram_addr [2];
    logic [31:0] sram_wdata [2];
    logic        sram_wdata_oe [2];
    logic [31:0] sram_rdata [2];
    logic        sram_ce_n [2];
    logic        sram_oe_n [2];
    logic        sram_we_n [2];
    logic [3:0]  sram_be_n [2];

    logic [31:0] smem [2][64];
    logic [31:0] rmem [2][64];
    logic [31:0] cur_if [2];
    logic [31:0] cur_d [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_arbiter #(.ADDR_W(20), .WAIT_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]), .if_ready(if_ready[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_be(d_be[g]), .d_addr(d_addr[g]),
            .d_wdata(d_wdata[g]), .d_rdata(d_rdata[g]), .d_ready(d_ready[g]),
            .stall_req(stall_req[g]),
            .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]), .sram_wdata_oe(sram_wdata_oe[g]),
            .sram_rdata(sram_rdata[g]), .sram_ce_n(sram_ce_n[g]), .sram_oe_n(sram_oe_n[g]),
            .sram_we_n(sram_we_n[g]), .sram_be_n(sram_be_n[g])
        );
        assign sram_rdata[g] = (!sram_ce_n[g] && !sram_oe_n[g]) ? smem[g][sram_addr[g][5:0]] : 32'hBADBAD00;
    end

    function automatic logic [31:0] init_word(input int a);
        if (a == 1) return 32'h34020001;
        return 32'h1000_0000 + 32'(a) * 32'h0001_0001;
    endfunction

    // Behavioural SRAM pins: byte-masked writes while CE and WE are low.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_load) begin
                for (int a = 0; a < 64; a++) smem[i][a] <= init_word(a);
            end else if (!sram_ce_n[i] && !sram_we_n[i]) begin
                for (int b = 0; b < 4; b++)
                    if (!sram_be_n[i][b]) smem[i][sram_addr[i][5:0]][8*b +: 8] <= sram_wdata[i][8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    // Reference model: word-level memory and last returned read value per port.
    function automatic logic [31:0] model_apply(input int g, input bit is_d, input bit we,
                                                input logic [3:0] be, input logic [31:0] addr,
                                                input logic [31:0] wdata);
        int word = int'((addr >> 2) & 32'h0000_003F);
        logic [31:0] v;
        if (is_d && we) begin
            v = rmem[g][word];
            for (int b = 0; b < 4; b++)
                if (be[b]) v[8*b +: 8] = wdata[8*b +: 8];
            rmem[g][word] = v;
            return cur_d[g];
        end
        if (is_d) cur_d[g] = rmem[g][word];
        else      cur_if[g] = rmem[g][word];
        return rmem[g][word];
    endfunction

    // Entered at posedge+1 of the grant cycle with the DUT idle; leaves at posedge+1 of the next IDLE cycle.
    task automatic run_txn(input int g, input bit is_d, input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata, input bit other_if,
                           input logic [19:0] exp_addr, input logic [3:0] exp_be_n,
                           input logic [31:0] exp_rdata, output int rdy_cyc);
        if (is_d) begin
            d_req[g] = 1'b1; d_we[g] = we; d_be[g] = be; d_addr[g] = addr; d_wdata[g] = wdata;
        end else begin
            if_req[g] = 1'b1; if_addr[g] = addr;
        end
        @(negedge clk);
        chk("grant_stall", 32'(stall_req[g]), 1);
        chk("grant_ce_n", 32'(sram_ce_n[g]), 1);
        for (int k = 1; k <= wait_of(g); k++) begin
            @(posedge clk); #1;
            if (is_d) begin
                d_addr[g] = $urandom; d_wdata[g] = $urandom; d_be[g] = 4'($urandom); d_we[g] = 1'($urandom);
            end else begin
                if_addr[g] = $urandom;
            end
            @(negedge clk);
            chk("acc_ce_n", 32'(sram_ce_n[g]), 0);
            chk("acc_addr", 32'(sram_addr[g]), 32'(exp_addr));
            chk("acc_oe_n", 32'(sram_oe_n[g]), 32'(we));
            chk("acc_we_n", 32'(sram_we_n[g]), 32'(!we));
            chk("acc_be_n", 32'(sram_be_n[g]), 32'(exp_be_n));
            chk("acc_wdata_oe", 32'(sram_wdata_oe[g]), 32'(we));
            if (we) chk("acc_wdata", sram_wdata[g], wdata);
            chk("acc_stall", 32'(stall_req[g]), 1);
            chk("acc_ready", {30'd0, if_ready[g], d_ready[g]}, 0);
        end
        @(posedge clk);
        @(negedge clk);
        rdy_cyc = cyc;
        chk("rdy_if", 32'(if_ready[g]), 32'(!is_d));
        chk("rdy_d", 32'(d_ready[g]), 32'(is_d));
        chk("rdy_ce_n", 32'(sram_ce_n[g]), 1);
        chk("rdy_oe_n", 32'(sram_oe_n[g]), 1);
        chk("rdy_we_n", 32'(sram_we_n[g]), 1);
        chk("rdy_be_n", 32'(sram_be_n[g]), 32'hF);
        chk("rdy_wdata_oe", 32'(sram_wdata_oe[g]), 0);
        chk(is_d ? "d_rdata" : "if_rdata", is_d ? d_rdata[g] : if_rdata[g], exp_rdata);
        chk("rdy_stall", 32'(stall_req[g]), 32'(other_if));
        @(posedge clk); #1;
        if (is_d) d_req[g] = 1'b0;
        else      if_req[g] = 1'b0;
    endtask

    typedef struct {
        bit          is_d;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be_n;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        int rc, rc0, c0, prev, w, mode, word, gap;
        logic [31:0] a, wd, r, e, ea;
        logic [3:0] be;
        bit we;

        tbl[0] = '{0, 0, 4'h0, 32'h0000_0004, 32'h0,         20'd1,  4'h0, 32'h3402_0001};
        tbl[1] = '{1, 1, 4'h3, 32'h0000_0010, 32'hDEAD_BEEF, 20'd4,  4'hC, 32'h0000_0000};
        tbl[2] = '{1, 0, 4'h0, 32'h0000_0010, 32'h0,         20'd4,  4'h0, 32'h1004_BEEF};
        tbl[3] = '{1, 1, 4'h0, 32'hFFC0_0012, 32'h1111_2222, 20'd4,  4'hF, 32'h1004_BEEF};
        tbl[4] = '{1, 0, 4'h0, 32'h0000_0013, 32'h0,         20'd4,  4'h0, 32'h1004_BEEF};
        tbl[5] = '{0, 0, 4'h0, 32'hABC0_00FC, 32'h0,         20'd63, 4'h0, 32'h103F_003F};
        tbl[6] = '{0, 0, 4'h0, 32'h0000_0008, 32'h0,         20'd2,  4'h0, 32'h1002_0002};

        rst = 1'b1;
        mem_load = 1'b1;
        for (int g = 0; g < 2; g++) begin
            if_req[g] = 0; if_addr[g] = 0; d_req[g] = 0; d_we[g] = 0; d_be[g] = 0;
            d_addr[g] = 0; d_wdata[g] = 0; cur_if[g] = 0; cur_d[g] = 0;
            for (int i = 0; i < 64; i++) rmem[g][i] = init_word(i);
        end
        #2;
        for (int g = 0; g < 2; g++) begin
            chk("rst_if_ready", 32'(if_ready[g]), 0);
            chk("rst_d_ready", 32'(d_ready[g]), 0);
            chk("rst_if_rdata", if_rdata[g], 0);
            chk("rst_d_rdata", d_rdata[g], 0);
            chk("rst_sram_addr", 32'(sram_addr[g]), 0);
            chk("rst_sram_wdata", sram_wdata[g], 0);
            chk("rst_wdata_oe", 32'(sram_wdata_oe[g]), 0);
            chk("rst_ce_n", 32'(sram_ce_n[g]), 1);
            chk("rst_oe_n", 32'(sram_oe_n[g]), 1);
            chk("rst_we_n", 32'(sram_we_n[g]), 1);
            chk("rst_be_n", 32'(sram_be_n[g]), 32'hF);
            chk("rst_stall", 32'(stall_req[g]), 0);
        end
        @(posedge clk); #1;
        mem_load = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed single transactions on the WAIT_CYCLES=1 instance.
        for (int i = 0; i < 7; i++) begin
            void'(model_apply(0, tbl[i].is_d, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata));
            run_txn(0, tbl[i].is_d, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, 1'b0,
                    tbl[i].exp_addr, tbl[i].exp_be_n, tbl[i].exp_rdata, rc);
        end

        // Simultaneous requests: data first, fetch granted in the turnaround IDLE cycle.
        for (int g = 0; g < 2; g++) begin
            w = wait_of(g);
            c0 = cyc;
            if_req[g] = 1'b1;
            if_addr[g] = 32'h0000_0008;
            e = model_apply(g, 1, 0, 4'h0, 32'h0000_0004, 0);
            run_txn(g, 1, 0, 4'h0, 32'h0000_0004, 0, 1'b1, 20'd1, 4'h0, e, rc);
            chk("both_d_latency", 32'(rc - c0), 32'(w + 1));
            e = model_apply(g, 0, 0, 4'h0, 32'h0000_0008, 0);
            run_txn(g, 0, 0, 4'h0, 32'h0000_0008, 0, 1'b0, 20'd2, 4'h0, e, rc0);
            chk("both_if_latency", 32'(rc0 - c0), 32'(2 * w + 3));
        end

        // Reset in the middle of a store's access cycle.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_be[0] = 4'hF; d_addr[0] = 32'h0000_0020; d_wdata[0] = 32'h1234_5678;
        @(posedge clk); #1;
        chk("prerst_we_n", 32'(sram_we_n[0]), 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ce_n", 32'(sram_ce_n[0]), 1);
        chk("midrst_we_n", 32'(sram_we_n[0]), 1);
        chk("midrst_wdata_oe", 32'(sram_wdata_oe[0]), 0);
        chk("midrst_be_n", 32'(sram_be_n[0]), 32'hF);
        d_req[0] = 1'b0;
        #1 rst = 1'b0;
        for (int g = 0; g < 2; g++) begin cur_if[g] = 0; cur_d[g] = 0; end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("postrst_d_ready", 32'(d_ready[0]), 0);
            chk("postrst_ce_n", 32'(sram_ce_n[0]), 1);
        end
        @(posedge clk); #1;
        e = model_apply(0, 1, 1, 4'hF, 32'h0000_0020, 32'h1234_5678);
        run_txn(0, 1, 1, 4'hF, 32'h0000_0020, 32'h1234_5678, 1'b0, 20'd8, 4'h0, e, rc);
        e = model_apply(0, 1, 0, 4'h0, 32'h0000_0020, 0);
        run_txn(0, 1, 0, 4'h0, 32'h0000_0020, 0, 1'b0, 20'd8, 4'h0, e, rc);

        // Fetch held continuously with a fresh address after each ready.
        for (int g = 0; g < 2; g++) begin
            prev = 0;
            for (int i = 0; i < 4; i++) begin
                a = 32'h0000_0028 + 32'(4 * i);
                e = model_apply(g, 0, 0, 4'h0, a, 0);
                run_txn(g, 0, 0, 4'h0, a, 0, 1'b0, 20'(10 + i), 4'h0, e, rc);
                if (i > 0) chk("refetch_period", 32'(rc - prev), 32'(wait_of(g) + 2));
                prev = rc;
            end
        end

        // Randomized rounds against the reference model.
        for (int g = 0; g < 2; g++) begin
            for (int n = 0; n < 40; n++) begin
                mode = $urandom_range(0, 2);
                word = $urandom_range(0, 63);
                r = $urandom;
                a = (r & 32'hFFC0_0003) | (32'(word) << 2);
                wd = $urandom;
                be = 4'($urandom);
                we = 1'($urandom);
                if (mode == 0) begin
                    e = model_apply(g, 0, 0, 4'h0, a, 0);
                    run_txn(g, 0, 0, 4'h0, a, 0, 1'b0, 20'(word), 4'h0, e, rc);
                end else begin
                    ea = (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'hFFC0_0003);
                    if (mode == 2) begin
                        if_req[g] = 1'b1;
                        if_addr[g] = ea;
                    end
                    e = model_apply(g, 1, we, be, a, wd);
                    run_txn(g, 1, we, be, a, wd, mode == 2, 20'(word), we ? ~be : 4'h0, e, rc);
                    if (mode == 2) begin
                        e = model_apply(g, 0, 0, 4'h0, ea, 0);
                        run_txn(g, 0, 0, 4'h0, ea, 0, 1'b0, 20'((ea >> 2) & 32'h3F), 4'h0, e, rc);
                    end
                end
                gap = $urandom_range(0, 2);
                for (int k = 0; k < gap; k++) begin
                    @(negedge clk);
                    chk("idle_stall", 32'(stall_req[g]), 0);
                    chk("idle_ce_n", 32'(sram_ce_n[g]), 1);
                    @(posedge clk); #1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
